// File: rtl/vid_pattern_gen.sv
// Raster timing and test-pattern source for the HDMI transmitter input bus.
// Produces de/hsync/vsync and a 36-bit {R,G,B} pixel, one cycle after counter state.
module vid_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [35:0] solid_rgb,
  output logic        vid_de,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic [35:0] vid_d,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] L_H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] L_H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] L_HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] L_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] L_V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] L_V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] L_VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] L_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] L_BAR_LAST = 12'(BAR_W - 1);

  localparam logic [35:0] C_WHITE = 36'hFFF_FFF_FFF;
  localparam logic [35:0] C_BLACK = 36'h000_000_000;

  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic [11:0] r_bar_cnt;
  logic [2:0]  r_bar_idx;
  logic [1:0]  r_pat;
  logic [35:0] r_solid;

  logic [11:0] w_h_nxt;
  logic [11:0] w_v_nxt;
  logic [11:0] w_bar_cnt_nxt;
  logic [2:0]  w_bar_idx_nxt;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_sof;
  logic        w_h_act;
  logic        w_de;
  logic        w_hs_act;
  logic        w_vs_act;
  logic [1:0]  w_pat;
  logic [35:0] w_solid;
  logic [35:0] w_bar_rgb;
  logic [35:0] w_pix;

  assign w_h_wrap = (r_h_cnt == L_H_LAST);
  assign w_v_wrap = (r_v_cnt == L_V_LAST);
  assign w_sof    = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
  assign w_h_act  = (r_h_cnt < L_H_ACT);
  assign w_de     = w_h_act && (r_v_cnt < L_V_ACT);
  assign w_hs_act = (r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END);
  assign w_vs_act = (r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END);

  // First pixel of a frame already uses the freshly latched selection.
  assign w_pat   = w_sof ? pattern_sel : r_pat;
  assign w_solid = w_sof ? solid_rgb : r_solid;

  // Raster position advance; disable parks the raster at the origin.
  always_comb begin
    w_h_nxt = r_h_cnt + 12'd1;
    w_v_nxt = r_v_cnt;
    if (!enable) begin
      w_h_nxt = 12'd0;
      w_v_nxt = 12'd0;
    end else if (w_h_wrap) begin
      w_h_nxt = 12'd0;
      w_v_nxt = w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
    end
  end

  // Bar tracker: steps the bar index every BAR_W active pixels, last bar
  // soaks up the remainder so no divider is needed.
  always_comb begin
    w_bar_cnt_nxt = r_bar_cnt;
    w_bar_idx_nxt = r_bar_idx;
    if (!enable || w_h_wrap) begin
      w_bar_cnt_nxt = 12'd0;
      w_bar_idx_nxt = 3'd0;
    end else if (w_h_act) begin
      if (r_bar_cnt == L_BAR_LAST && r_bar_idx != 3'd7) begin
        w_bar_cnt_nxt = 12'd0;
        w_bar_idx_nxt = r_bar_idx + 3'd1;
      end else begin
        w_bar_cnt_nxt = r_bar_cnt + 12'd1;
      end
    end
  end

  // Bar colour table: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    w_bar_rgb = C_BLACK;
    unique case (r_bar_idx)
      3'd0: w_bar_rgb = 36'hFFF_FFF_FFF;
      3'd1: w_bar_rgb = 36'hFFF_FFF_000;
      3'd2: w_bar_rgb = 36'h000_FFF_FFF;
      3'd3: w_bar_rgb = 36'h000_FFF_000;
      3'd4: w_bar_rgb = 36'hFFF_000_FFF;
      3'd5: w_bar_rgb = 36'hFFF_000_000;
      3'd6: w_bar_rgb = 36'h000_000_FFF;
      3'd7: w_bar_rgb = 36'h000_000_000;
      default: w_bar_rgb = C_BLACK;
    endcase
  end

  // Pattern mux for the current raster position.
  always_comb begin
    w_pix = C_BLACK;
    unique case (w_pat)
      2'd0: w_pix = w_solid;
      2'd1: w_pix = w_bar_rgb;
      2'd2: w_pix = {r_h_cnt, r_h_cnt, r_h_cnt};
      2'd3: w_pix = (r_h_cnt[4] ^ r_v_cnt[4]) ? C_WHITE : C_BLACK;
      default: w_pix = C_BLACK;
    endcase
  end

  // Raster counters and bar tracker state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt   <= 12'd0;
      r_v_cnt   <= 12'd0;
      r_bar_cnt <= 12'd0;
      r_bar_idx <= 3'd0;
    end else begin
      r_h_cnt   <= w_h_nxt;
      r_v_cnt   <= w_v_nxt;
      r_bar_cnt <= w_bar_cnt_nxt;
      r_bar_idx <= w_bar_idx_nxt;
    end
  end

  // Pattern selection is sampled only at the frame origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat   <= 2'd0;
      r_solid <= 36'd0;
    end else if (enable && w_sof) begin
      r_pat   <= pattern_sel;
      r_solid <= solid_rgb;
    end
  end

  // Registered video outputs, idle whenever the raster is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_de      <= 1'b0;
      vid_hsync   <= ~HS_POL;
      vid_vsync   <= ~VS_POL;
      vid_d       <= 36'd0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      vid_de      <= 1'b0;
      vid_hsync   <= ~HS_POL;
      vid_vsync   <= ~VS_POL;
      vid_d       <= 36'd0;
      frame_start <= 1'b0;
    end else begin
      vid_de      <= w_de;
      vid_hsync   <= w_hs_act ? HS_POL : ~HS_POL;
      vid_vsync   <= w_vs_act ? VS_POL : ~VS_POL;
      vid_d       <= w_de ? w_pix : 36'd0;
      frame_start <= w_sof;
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen: small raster, per-cycle model compare
// plus directed literal checks of timing, patterns, enable and reset.
module tb_vid_pattern_gen;

  localparam int HA  = 44;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 6;
  localparam int VA  = 20;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [35:0] solid_rgb = 36'd0;
  logic        vid_de;
  logic        vid_hsync;
  logic        vid_vsync;
  logic [35:0] vid_d;
  logic        vid_frame_start;

  int checks = 0;
  int failures = 0;

  vid_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb),
    .vid_de(vid_de),
    .vid_hsync(vid_hsync),
    .vid_vsync(vid_vsync),
    .vid_d(vid_d),
    .frame_start(vid_frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act,
                     input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [35:0] bar_tab [8] = '{36'hFFFFFFFFF, 36'hFFFFFF000,
                               36'h000FFFFFF, 36'h000FFF000,
                               36'hFFF000FFF, 36'hFFF000000,
                               36'h000000FFF, 36'h000000000};

  function automatic logic [35:0] model_pix(input int p, input logic [35:0] s,
                                            input int x, input int y);
    int b;
    logic [11:0] xv;
    xv = 12'(x);
    case (p)
      0: return s;
      1: begin
        b = x / (HA / 8);
        if (b > 7) b = 7;
        return bar_tab[b];
      end
      2: return {xv, xv, xv};
      default: return (((x / 16) + (y / 16)) % 2 == 1) ? 36'hFFFFFFFFF : 36'h0;
    endcase
  endfunction

  int          mx = 0;
  int          my = 0;
  int          mpat = 0;
  logic [35:0] msol = 36'd0;
  logic        e_de = 1'b0;
  logic        e_hs = 1'b1;
  logic        e_vs = 1'b1;
  logic [35:0] e_d = 36'd0;
  logic        e_fs = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      mx <= 0; my <= 0;
      e_de <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1;
      e_d <= 36'd0; e_fs <= 1'b0;
      if (reset) begin
        mpat <= 0; msol <= 36'd0;
      end
    end else begin
      if (mx == 0 && my == 0) begin
        mpat <= int'(pattern_sel);
        msol <= solid_rgb;
      end
      e_de <= (mx < HA) && (my < VA);
      e_hs <= !(mx >= HA + HFP && mx < HA + HFP + HSW);
      e_vs <= !(my >= VA + VFP && my < VA + VFP + VSW);
      e_fs <= (mx == 0 && my == 0);
      if (mx < HA && my < VA)
        e_d <= (mx == 0 && my == 0)
               ? model_pix(int'(pattern_sel), solid_rgb, mx, my)
               : model_pix(mpat, msol, mx, my);
      else
        e_d <= 36'd0;
      if (mx == HT - 1) begin
        mx <= 0;
        my <= (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx <= mx + 1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("de", {35'd0, vid_de}, {35'd0, e_de});
    chk("hsync", {35'd0, vid_hsync}, {35'd0, e_hs});
    chk("vsync", {35'd0, vid_vsync}, {35'd0, e_vs});
    chk("data", vid_d, e_d);
    chk("frame_start", {35'd0, vid_frame_start}, {35'd0, e_fs});
  end

  // ---------------- frame statistics monitor ----------------
  int m_len = 0, m_de = 0, m_hs = 0, m_vs = 0, m_hs1 = -1, m_vs1 = -1;
  int s_len = 0, s_de = 0, s_hs = 0, s_vs = 0, s_hs1 = -1, s_vs1 = -1;

  always @(negedge clk) begin
    if (vid_frame_start) begin
      s_len <= m_len; s_de <= m_de; s_hs <= m_hs; s_vs <= m_vs;
      s_hs1 <= m_hs1; s_vs1 <= m_vs1;
      m_len <= 1;
      m_de  <= int'(vid_de);
      m_hs  <= int'(!vid_hsync);
      m_vs  <= int'(!vid_vsync);
      m_hs1 <= -1;
      m_vs1 <= -1;
    end else begin
      m_len <= m_len + 1;
      m_de  <= m_de + int'(vid_de);
      m_hs  <= m_hs + int'(!vid_hsync);
      m_vs  <= m_vs + int'(!vid_vsync);
      if (!vid_hsync && m_hs1 < 0) m_hs1 <= m_len;
      if (!vid_vsync && m_vs1 < 0) m_vs1 <= m_len;
    end
  end

  task automatic wait_fs();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (vid_frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_frame_start actual=timeout required=pulse");
    end
  endtask

  logic [35:0] row [HA];

  initial begin
    reset = 1'b1;
    pattern_sel = 2'd1;
    repeat (3) @(negedge clk);
    chk("rst_hsync", {35'd0, vid_hsync}, 36'd1);
    chk("rst_vsync", {35'd0, vid_vsync}, 36'd1);
    chk("rst_de", {35'd0, vid_de}, 36'd0);
    chk("rst_d", vid_d, 36'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 enable = 1'b1;

    // Colour bars, BAR_W=5, last bar 9 px wide.
    wait_fs();
    for (int k = 0; k < HA; k++) begin
      row[k] = vid_d;
      @(negedge clk);
    end
    chk("bar_px0", row[0], 36'hFFF_FFF_FFF);
    chk("bar_px5", row[5], 36'hFFF_FFF_000);
    chk("bar_px10", row[10], 36'h000_FFF_FFF);
    chk("bar_px34", row[34], 36'h000_000_FFF);
    chk("bar_px35", row[35], 36'h000_000_000);
    chk("bar_px43", row[43], 36'h000_000_000);

    // Timing of a complete frame.
    pattern_sel = 2'd0;
    solid_rgb = 36'h123_456_789;
    wait_fs();
    @(posedge clk);
    #1;
    chk("frame_len", 36'(s_len), 36'(HT * VT));
    chk("de_clks", 36'(s_de), 36'(HA * VA));
    chk("hs_clks", 36'(s_hs), 36'(HSW * VT));
    chk("vs_clks", 36'(s_vs), 36'(VSW * HT));
    chk("hs_offset", 36'(s_hs1), 36'd48);
    chk("vs_offset", 36'(s_vs1), 36'd1320);

    // Mid-frame pattern change waits for the next frame.
    wait_fs();
    repeat (300) @(negedge clk);
    #2;
    pattern_sel = 2'd2;
    solid_rgb = 36'hABC;
    repeat (305) @(negedge clk);
    chk("solid_hold", vid_d, 36'h123_456_789);
    wait_fs();
    repeat (5) @(negedge clk);
    chk("ramp_px5", vid_d, 36'h005_005_005);
    repeat (38) @(negedge clk);
    chk("ramp_px43", vid_d, 36'h02B_02B_02B);

    // Checkerboard.
    pattern_sel = 2'd3;
    wait_fs();
    chk("chk_0_0", vid_d, 36'h0);
    repeat (16) @(negedge clk);
    chk("chk_16_0", vid_d, 36'hFFF_FFF_FFF);
    repeat (944) @(negedge clk);
    chk("chk_0_16", vid_d, 36'hFFF_FFF_FFF);
    repeat (16) @(negedge clk);
    chk("chk_16_16", vid_d, 36'h0);

    // Enable drop mid-line.
    wait_fs();
    repeat (20) @(negedge clk);
    #2 enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {vid_de, vid_hsync, vid_vsync, vid_frame_start, vid_d},
          {1'b0, 1'b1, 1'b1, 1'b0, 36'd0});
    end
    #2 enable = 1'b1;
    @(negedge clk);
    chk("fs_after_enable", {35'd0, vid_frame_start}, 36'd1);
    repeat (16) @(negedge clk);
    chk("restart_px16", vid_d, 36'hFFF_FFF_FFF);

    // Asynchronous reset mid-active.
    pattern_sel = 2'd1;
    wait_fs();
    repeat (10) @(negedge clk);
    chk("pre_rst_de", {35'd0, vid_de}, 36'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {vid_de, vid_d}, 37'd0);
    pattern_sel = 2'd0;
    solid_rgb = 36'd0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("fs_after_rst", {35'd0, vid_frame_start}, 36'd1);
    chk("de_after_rst", {35'd0, vid_de}, 36'd1);
    repeat (3) @(negedge clk);
    chk("d_after_rst", vid_d, 36'd0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
